load_unit: RTL and testbench
============================

Name: load_unit

Overview:
- Read-side counterpart of the store path. Takes load operations from the LSU issue stage and issues virtually-indexed, physically-tagged read requests to the D$ load port.
- Requests address translation, blocks on page-offset hazards against the store buffer, and aligns and sign-extends the returned data.
- Writes back to the LSU result bus with the transaction ID, or with the translation/access exception.
- Allows one outstanding load.

Parameters:
- DCACHE_INDEX_WIDTH, 12, width of the index (page-offset) field sent with the request.
- DCACHE_TAG_WIDTH, riscv::PLEN-12, width of the physical tag sent one cycle after grant.

Ports:
- clk_i  in  1  clock; the single clock for the block.
- rst_i  in  1  reset; synchronous and active-high.
- flush_i  in  1  kill any in-flight load.
- valid_i  in  1  a load is presented on lsu_ctrl_i.
- lsu_ctrl_i  in  lsu_ctrl_t  vaddr, operator, trans_id, be.
- pop_ld_o  out  1  load accepted; issue stage may dequeue.
- valid_o  out  1  writeback valid.
- trans_id_o  out  TRANS_ID_BITS  ID of the completing load.
- result_o  out  riscv::XLEN  aligned, extended load data.
- ex_o  out  exception_t  exception for the completing load.
- translation_req_o  out  1  MMU request.
- vaddr_o  out  riscv::VLEN  address to translate.
- paddr_i  in  riscv::PLEN  translated address.
- ex_i  in  exception_t  MMU exception.
- dtlb_hit_i  in  1  translation hit in the same cycle as the request.
- page_offset_o  out  12  vaddr[11:0] of the current load.
- page_offset_matches_i  in  1  the store buffer holds a store with an equal offset.
- req_port_i  in  dcache_req_o_t  data_gnt, data_rvalid, data_rdata.
- req_port_o  out  dcache_req_i_t  address_index, address_tag, data_req, tag_valid, kill_req, data_we=0, data_be, data_size.

Behaviour:
- Reset (rst_i high at a clock edge):
  - state is IDLE.
  - All outputs are 0, except ex_o = ex_i passthrough with valid forced 0.
  - Captured registers are cleared.
- States: IDLE, WAIT_GNT, SEND_TAG, WAIT_TRANSLATION, WAIT_RVALID, WAIT_FLUSH.
- IDLE with valid_i:
  - If page_offset_matches_i: stay in IDLE with no request (hazard stall).
  - Otherwise: data_req=1, translation_req_o=1, and capture vaddr[2:0], operator and trans_id.
  - data_gnt -> SEND_TAG; no grant -> WAIT_GNT.
- WAIT_GNT:
  - Hold data_req=1 and the index stable.
  - Go to SEND_TAG on data_gnt.
  - Continue checking the page-offset hazard; on a match, drop data_req and return to IDLE.
- SEND_TAG: translation_req_o=1, address_tag = paddr_i[PLEN-1:12].
  - ex_i.valid: kill_req=1, valid_o=1 and ex_o=ex_i, pop_ld_o=1 -> IDLE.
  - Otherwise, !dtlb_hit_i: kill_req=1 -> WAIT_TRANSLATION.
  - Otherwise: tag_valid=1, pop_ld_o=1 -> WAIT_RVALID.
- WAIT_TRANSLATION: translation_req_o=1; on dtlb_hit_i -> IDLE, which re-issues the request.
- WAIT_RVALID:
  - On data_rvalid: valid_o=1 combinationally in the same cycle, result_o from data_rdata -> IDLE.
  - Minimum latency is grant cycle + 2.
- Result extraction:
  - Shift data_rdata right by 8*vaddr_q[2:0].
  - LB/LH/LW sign-extend from bit 7/15/31; LBU/LHU/LWU zero-extend; LD passes through.
  - For XLEN=32, LW passes through.
- Flush:
  - In WAIT_GNT: -> IDLE, drop data_req.
  - In SEND_TAG: kill_req=1 -> IDLE.
  - In WAIT_RVALID: -> WAIT_FLUSH, which swallows one data_rvalid without asserting valid_o, then -> IDLE.
  - flush_i together with data_rvalid in WAIT_RVALID: data is dropped; go directly to IDLE.
  - valid_o is never asserted in a cycle where flush_i is high.
- data_be and data_size come from lsu_ctrl_i.be and extract_transfer_size(operator).
- pop_ld_o is asserted exactly once per load that completes or faults.

Decomposition:
- ariane_pkg: lsu_ctrl_t, exception_t, dcache_req_i_t/dcache_req_o_t, fu_op load encodings, extract_transfer_size, TRANS_ID_BITS.
- Sub-module load_data_align: combinational shift plus sign/zero extension, tested standalone.

Test Plan:
- LW, vaddr 0x1004, grant immediate, hit, rdata 0x8000_0000_0000_0000 -> tag_valid on cycle 1, valid_o on rvalid cycle, result_o=0x0000_0000_8000_0000 >> ... i.e. upper word 0x8000_0000 sign-extended = 0xFFFF_FFFF_8000_0000, trans_id echoed.
- LBU, vaddr offset 3, rdata 0x0000_0000_FF00_0000 -> result_o=0xFF. LB on the same data -> 0xFFFF_FFFF_FFFF_FFFF.
- dtlb miss in SEND_TAG -> kill_req=1, WAIT_TRANSLATION; hit after 5 cycles -> request re-issued, single pop_ld_o.
- ex_i.valid (load page fault) in SEND_TAG -> kill_req=1, valid_o=1, ex_o.valid=1, no tag_valid.
- page_offset_matches_i high for 4 cycles -> no data_req during those cycles; request issues the cycle after it drops.
- flush_i in WAIT_RVALID, rvalid 2 cycles later -> valid_o stays 0; next load completes normally. Also assert rst_i mid-WAIT_RVALID -> IDLE, all outputs 0.

Source files
------------

// File: rtl/load_unit_pkg.sv
// Shared types for the load unit: LSU control, exceptions, D$ load port
// bundles, load operator encodings and the transfer-size helper.
package load_unit_pkg;

    localparam int XLEN = 64;
    localparam int VLEN = 64;
    localparam int PLEN = 56;
    localparam int TRANS_ID_BITS = 3;
    localparam int DCACHE_INDEX_WIDTH = 12;
    localparam int DCACHE_TAG_WIDTH = PLEN - 12;

    typedef enum logic [3:0] {
        LD, LW, LWU, LH, LHU, LB, LBU
    } fu_op_t;

    typedef struct packed {
        logic [VLEN-1:0]          vaddr;
        fu_op_t                   operator;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [7:0]               be;
    } lsu_ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic                          data_req;
        logic                          data_we;
        logic [7:0]                    data_be;
        logic [1:0]                    data_size;
        logic                          tag_valid;
        logic                          kill_req;
    } dcache_req_i_t;

    typedef struct packed {
        logic            data_gnt;
        logic            data_rvalid;
        logic [XLEN-1:0] data_rdata;
    } dcache_req_o_t;

    function automatic logic [1:0] extract_transfer_size(fu_op_t op);
        logic [1:0] size;
        case (op)
            LD:       size = 2'b11;
            LW, LWU:  size = 2'b10;
            LH, LHU:  size = 2'b01;
            default:  size = 2'b00;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/load_unit_if.sv
// D$ load port: request bundle from the load unit, response from the cache.
interface load_unit_if;
    import load_unit_pkg::*;

    dcache_req_i_t req_port_o;
    dcache_req_o_t req_port_i;

    modport master (output req_port_o, input req_port_i);
    modport slave  (input req_port_o, output req_port_i);

endinterface

// File: rtl/load_unit_align.sv
// Load data alignment: shift the returned doubleword down to the byte
// offset and sign- or zero-extend according to the load operator.
module load_data_align import load_unit_pkg::*; (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      offset_i,
    input  fu_op_t          op_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0]    shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] word_s;

    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        byte_s  = shifted[7:0];
        half_s  = shifted[15:0];
        word_s  = shifted[31:0];
        data_o  = shifted;
        // signed casts sign-extend; on XLEN=32 the LW cast is a pass-through
        unique case (op_i)
            LB:      data_o = XLEN'(byte_s);
            LBU:     data_o = XLEN'(shifted[7:0]);
            LH:      data_o = XLEN'(half_s);
            LHU:     data_o = XLEN'(shifted[15:0]);
            LW:      data_o = XLEN'(word_s);
            LWU:     data_o = XLEN'(shifted[31:0]);
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load unit: VIPT read requests to the D$, translation, store-offset hazard
// stall, flush handling and aligned writeback. One load in flight.
module load_unit import load_unit_pkg::*; (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     valid_i,
    input  lsu_ctrl_t                lsu_ctrl_i,
    output logic                     pop_ld_o,
    output logic                     valid_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o,
    output logic [XLEN-1:0]          result_o,
    output exception_t               ex_o,
    output logic                     translation_req_o,
    output logic [VLEN-1:0]          vaddr_o,
    input  logic [PLEN-1:0]          paddr_i,
    input  exception_t               ex_i,
    input  logic                     dtlb_hit_i,
    output logic [11:0]              page_offset_o,
    input  logic                     page_offset_matches_i,
    load_unit_if.master              dcache
);

    typedef enum logic [2:0] {
        IDLE, WAIT_GNT, SEND_TAG,
        WAIT_TRANSLATION, WAIT_RVALID, WAIT_FLUSH
    } state_t;

    state_t                   state_q, state_d;
    logic [2:0]               offset_q, offset_d;
    fu_op_t                   op_q, op_d;
    logic [TRANS_ID_BITS-1:0] trans_id_q, trans_id_d;

    logic            gnt, rvalid;
    logic [XLEN-1:0] aligned;
    dcache_req_i_t   req;
    logic            unused_paddr;

    assign gnt          = dcache.req_port_i.data_gnt;
    assign rvalid       = dcache.req_port_i.data_rvalid;
    assign unused_paddr = ^paddr_i[11:0];

    load_data_align u_align (
        .rdata_i  (dcache.req_port_i.data_rdata),
        .offset_i (offset_q),
        .op_i     (op_q),
        .data_o   (aligned)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            offset_q   <= '0;
            op_q       <= LD;
            trans_id_q <= '0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            op_q       <= op_d;
            trans_id_q <= trans_id_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        offset_d          = offset_q;
        op_d              = op_q;
        trans_id_d        = trans_id_q;
        req               = '0;
        pop_ld_o          = 1'b0;
        valid_o           = 1'b0;
        result_o          = '0;
        translation_req_o = 1'b0;
        vaddr_o           = '0;
        page_offset_o     = '0;
        ex_o              = ex_i;
        ex_o.valid        = 1'b0;
        if (!rst_i) begin
            req.address_index = lsu_ctrl_i.vaddr[11:0];
            req.address_tag   = paddr_i[PLEN-1:12];
            req.data_be       = lsu_ctrl_i.be;
            req.data_size     = extract_transfer_size(lsu_ctrl_i.operator);
            vaddr_o           = lsu_ctrl_i.vaddr;
            page_offset_o     = lsu_ctrl_i.vaddr[11:0];
            unique case (state_q)
                IDLE: begin
                    if (valid_i && !page_offset_matches_i) begin
                        req.data_req      = 1'b1;
                        translation_req_o = 1'b1;
                        offset_d          = lsu_ctrl_i.vaddr[2:0];
                        op_d              = lsu_ctrl_i.operator;
                        trans_id_d        = lsu_ctrl_i.trans_id;
                        state_d           = gnt ? SEND_TAG : WAIT_GNT;
                    end
                end
                WAIT_GNT: begin
                    if (flush_i || page_offset_matches_i) begin
                        state_d = IDLE;
                    end else begin
                        req.data_req      = 1'b1;
                        translation_req_o = 1'b1;
                        if (gnt) state_d = SEND_TAG;
                    end
                end
                SEND_TAG: begin
                    translation_req_o = 1'b1;
                    if (flush_i) begin
                        req.kill_req = 1'b1;
                        state_d      = IDLE;
                    end else if (ex_i.valid) begin
                        req.kill_req = 1'b1;
                        valid_o      = 1'b1;
                        ex_o         = ex_i;
                        pop_ld_o     = 1'b1;
                        state_d      = IDLE;
                    end else if (!dtlb_hit_i) begin
                        // IDLE replays the whole request once the TLB hits
                        req.kill_req = 1'b1;
                        state_d      = WAIT_TRANSLATION;
                    end else begin
                        req.tag_valid = 1'b1;
                        pop_ld_o      = 1'b1;
                        state_d       = WAIT_RVALID;
                    end
                end
                WAIT_TRANSLATION: begin
                    translation_req_o = 1'b1;
                    if (flush_i || dtlb_hit_i) state_d = IDLE;
                end
                WAIT_RVALID: begin
                    if (flush_i) begin
                        state_d = rvalid ? IDLE : WAIT_FLUSH;
                    end else if (rvalid) begin
                        valid_o  = 1'b1;
                        result_o = aligned;
                        state_d  = IDLE;
                    end
                end
                WAIT_FLUSH: begin
                    if (rvalid) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign dcache.req_port_o = req;
    assign trans_id_o        = trans_id_q;

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: directed scenarios plus randomized loads checked
// against a byte-level reference of RISC-V load semantics.
module tb_load_unit;
    import load_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_i, flush_i, valid_i, pop_ld_o, valid_o;
    logic translation_req_o, dtlb_hit_i, po_match;
    lsu_ctrl_t lsu_ctrl_i;
    logic [TRANS_ID_BITS-1:0] trans_id_o;
    logic [XLEN-1:0] result_o;
    exception_t ex_o, ex_i;
    logic [VLEN-1:0] vaddr_o;
    logic [PLEN-1:0] paddr_i;
    logic [11:0] page_offset_o;
    logic gnt, rvalid;
    logic [XLEN-1:0] rdata;
    dcache_req_i_t rq;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int valids, pops, reqs, tags, kills, lat, hzreq, first_req;
        logic [XLEN-1:0] res;
        logic [TRANS_ID_BITS-1:0] tid;
        logic [1:0] size;
        logic [7:0] be;
        exception_t ex;
    } obs_t;

    load_unit_if dc();

    assign dc.req_port_i = '{data_gnt: gnt, data_rvalid: rvalid, data_rdata: rdata};
    assign rq = dc.req_port_o;

    always #5 clk = ~clk;

    load_unit dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
        .lsu_ctrl_i(lsu_ctrl_i), .pop_ld_o(pop_ld_o), .valid_o(valid_o),
        .trans_id_o(trans_id_o), .result_o(result_o), .ex_o(ex_o),
        .translation_req_o(translation_req_o), .vaddr_o(vaddr_o),
        .paddr_i(paddr_i), .ex_i(ex_i), .dtlb_hit_i(dtlb_hit_i),
        .page_offset_o(page_offset_o),
        .page_offset_matches_i(po_match), .dcache(dc)
    );

    function automatic int op_bytes(fu_op_t op);
        if (op == LD) return 8;
        if (op == LW || op == LWU) return 4;
        if (op == LH || op == LHU) return 2;
        return 1;
    endfunction

    function automatic logic [63:0] ref_load(fu_op_t op, logic [2:0] off,
                                             logic [63:0] d);
        int nb = op_bytes(op);
        bit sx = (op == LB || op == LH || op == LW);
        logic [63:0] v, m;
        v = d >> (8 * off);
        if (nb == 8) return v;
        m = (64'd1 << (8 * nb)) - 64'd1;
        v = v & m;
        if (sx && v[8*nb-1]) v = v | ~m;
        return v;
    endfunction

    task automatic run_load(input fu_op_t op, input logic [VLEN-1:0] va,
                            input logic [TRANS_ID_BITS-1:0] tid,
                            input logic [XLEN-1:0] d, input int glat,
                            input int miss, input int rvlat, input int hz,
                            input logic fault, output obs_t o);
        int gw = 0, ml = miss, rc = 0, gcyc = -1;
        bit pend = 0, popped = 0, done = 0;
        o.valids = 0; o.pops = 0; o.reqs = 0; o.tags = 0; o.kills = 0;
        o.lat = -1; o.hzreq = 0; o.first_req = -1; o.res = '0;
        o.tid = '0; o.size = '0; o.be = '0; o.ex = '0;
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            @(negedge clk);
            valid_i = !popped;
            lsu_ctrl_i = '{vaddr: va, operator: op, trans_id: tid, be: 8'hA5};
            paddr_i = PLEN'(va);
            po_match = (cyc < hz);
            dtlb_hit_i = (ml == 0);
            ex_i.valid = fault;
            gnt = (gw >= glat);
            rvalid = pend && (rc == rvlat);
            rdata = rvalid ? d : {$urandom, $urandom};
            #1;
            if (rq.data_req) begin
                if (cyc < hz) o.hzreq++;
                if (o.first_req < 0) begin
                    o.first_req = cyc;
                    o.size = rq.data_size;
                    o.be = rq.data_be;
                end
                if (gnt) begin o.reqs++; gcyc = cyc; gw = 0; end
                else gw++;
            end
            if (rq.kill_req) o.kills++;
            if (rq.tag_valid) begin o.tags++; pend = 1; rc = 0; end
            else if (pend) begin
                if (rvalid) pend = 0;
                else rc++;
            end
            if (translation_req_o && !dtlb_hit_i && ml > 0) ml--;
            if (pop_ld_o) begin o.pops++; popped = 1; end
            if (valid_o) begin
                o.valids++; o.res = result_o; o.tid = trans_id_o;
                o.ex = ex_o; o.lat = cyc - gcyc; done = 1;
            end
        end
        @(negedge clk);
        valid_i = 0; gnt = 0; rvalid = 0; po_match = 0; ex_i.valid = 0;
    endtask

    task automatic issue_to_rvalid(input logic [TRANS_ID_BITS-1:0] tid,
                                   output bit ok);
        @(negedge clk);
        valid_i = 1; gnt = 1; rvalid = 0; dtlb_hit_i = 1;
        ex_i.valid = 0; po_match = 0; flush_i = 0;
        lsu_ctrl_i = '{vaddr: 64'h3000, operator: LD, trans_id: tid, be: 8'hFF};
        paddr_i = PLEN'(64'h3000);
        #1; ok = rq.data_req;
        @(negedge clk);
        #1; ok = ok && rq.tag_valid && pop_ld_o;
    endtask

    task automatic test_reset();
        rst_i = 1; valid_i = 1;
        lsu_ctrl_i = '{vaddr: 64'h5555, operator: LB, trans_id: 3'd6, be: 8'hFF};
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({rq.data_req, rq.tag_valid, rq.kill_req, translation_req_o} !== 4'b0) begin
            n_bad++; $display("FAIL reset_req got=%b exp=0",
                {rq.data_req, rq.tag_valid, rq.kill_req, translation_req_o});
        end
        n_cmp++;
        if ({valid_o, pop_ld_o, ex_o.valid} !== 3'b0) begin
            n_bad++; $display("FAIL reset_wb got=%b exp=0",
                {valid_o, pop_ld_o, ex_o.valid});
        end
        n_cmp++;
        if (result_o !== '0 || trans_id_o !== '0) begin
            n_bad++; $display("FAIL reset_data got=%h/%h exp=0", result_o, trans_id_o);
        end
        n_cmp++;
        if (page_offset_o !== '0 || vaddr_o !== '0) begin
            n_bad++; $display("FAIL reset_addr got=%h/%h exp=0", page_offset_o, vaddr_o);
        end
        n_cmp++;
        if (ex_o.cause !== ex_i.cause || ex_o.tval !== ex_i.tval) begin
            n_bad++; $display("FAIL reset_ex_pass got=%h exp=%h", ex_o.cause, ex_i.cause);
        end
        rst_i = 0; valid_i = 0;
    endtask

    task automatic test_lw_sign();
        obs_t o;
        run_load(LW, 64'h1004, 3'd5, 64'h8000_0000_0000_0000, 0, 0, 0, 0, 0, o);
        n_cmp++;
        if (o.valids !== 1 || o.res !== 64'hFFFF_FFFF_8000_0000) begin
            n_bad++; $display("FAIL lw_result got=%h(n=%0d) exp=ffffffff80000000",
                o.res, o.valids);
        end
        n_cmp++;
        if (o.tid !== 3'd5) begin
            n_bad++; $display("FAIL lw_tid got=%0d exp=5", o.tid);
        end
        n_cmp++;
        if (o.lat !== 2) begin
            n_bad++; $display("FAIL lw_latency got=%0d exp=2", o.lat);
        end
        n_cmp++;
        if (o.pops !== 1 || o.tags !== 1 || o.ex.valid !== 1'b0) begin
            n_bad++; $display("FAIL lw_pop_tag got=%0d/%0d/%b exp=1/1/0",
                o.pops, o.tags, o.ex.valid);
        end
        n_cmp++;
        if (o.size !== 2'b10 || o.be !== 8'hA5) begin
            n_bad++; $display("FAIL lw_size_be got=%0d/%h exp=2/a5", o.size, o.be);
        end
    endtask

    task automatic test_byte();
        obs_t o;
        run_load(LBU, 64'h2003, 3'd1, 64'h0000_0000_FF00_0000, 1, 0, 1, 0, 0, o);
        n_cmp++;
        if (o.valids !== 1 || o.res !== 64'hFF) begin
            n_bad++; $display("FAIL lbu_result got=%h(n=%0d) exp=ff", o.res, o.valids);
        end
        n_cmp++;
        if (o.lat !== 3) begin
            n_bad++; $display("FAIL lbu_latency got=%0d exp=3", o.lat);
        end
        run_load(LB, 64'h2003, 3'd2, 64'h0000_0000_FF00_0000, 2, 0, 0, 0, 0, o);
        n_cmp++;
        if (o.valids !== 1 || o.res !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_bad++; $display("FAIL lb_result got=%h(n=%0d) exp=ffffffffffffffff",
                o.res, o.valids);
        end
    endtask

    task automatic test_tlb_miss();
        obs_t o;
        logic [63:0] d = {$urandom, $urandom};
        run_load(LD, 64'h7_0008, 3'd3, d, 0, 5, 0, 0, 0, o);
        n_cmp++;
        if (o.kills !== 1 || o.reqs !== 2) begin
            n_bad++; $display("FAIL miss_replay got=kill%0d/req%0d exp=1/2",
                o.kills, o.reqs);
        end
        n_cmp++;
        if (o.pops !== 1 || o.valids !== 1) begin
            n_bad++; $display("FAIL miss_pop got=%0d/%0d exp=1/1", o.pops, o.valids);
        end
        n_cmp++;
        if (o.res !== d || o.tid !== 3'd3) begin
            n_bad++; $display("FAIL miss_result got=%h/%0d exp=%h/3", o.res, o.tid, d);
        end
    endtask

    task automatic test_fault();
        obs_t o;
        logic [63:0] tv = {$urandom, $urandom};
        ex_i.cause = 64'd13; ex_i.tval = tv;
        run_load(LW, 64'h9000, 3'd4, 64'h1, 0, 0, 0, 0, 1, o);
        n_cmp++;
        if (o.valids !== 1 || o.ex.valid !== 1'b1 || o.ex.cause !== 64'd13) begin
            n_bad++; $display("FAIL fault_wb got=%0d/%b/%0d exp=1/1/13",
                o.valids, o.ex.valid, o.ex.cause);
        end
        n_cmp++;
        if (o.ex.tval !== tv || o.tid !== 3'd4) begin
            n_bad++; $display("FAIL fault_tval got=%h/%0d exp=%h/4", o.ex.tval, o.tid, tv);
        end
        n_cmp++;
        if (o.tags !== 0 || o.kills !== 1 || o.pops !== 1) begin
            n_bad++; $display("FAIL fault_port got=tag%0d/kill%0d/pop%0d exp=0/1/1",
                o.tags, o.kills, o.pops);
        end
    endtask

    task automatic test_hazard();
        obs_t o;
        run_load(LHU, 64'h4002, 3'd7, 64'h0000_0000_BEEF_0000, 0, 0, 0, 4, 0, o);
        n_cmp++;
        if (o.hzreq !== 0 || o.first_req !== 4) begin
            n_bad++; $display("FAIL hazard_stall got=%0d/%0d exp=0/4", o.hzreq, o.first_req);
        end
        n_cmp++;
        if (o.valids !== 1 || o.res !== 64'hBEEF) begin
            n_bad++; $display("FAIL hazard_result got=%h exp=beef", o.res);
        end
    endtask

    task automatic test_flush();
        obs_t o;
        bit ok;
        int vbad = 0;
        issue_to_rvalid(3'd2, ok);
        @(negedge clk); valid_i = 0; flush_i = 1; #1; vbad += valid_o;
        @(negedge clk); flush_i = 0; #1; vbad += valid_o;
        @(negedge clk); rvalid = 1; rdata = {$urandom, $urandom}; #1; vbad += valid_o;
        @(negedge clk); rvalid = 0; #1; vbad += valid_o;
        n_cmp++;
        if (!ok || vbad !== 0) begin
            n_bad++; $display("FAIL flush_swallow got=ok%0d/valid%0d exp=1/0", ok, vbad);
        end
        run_load(LWU, 64'h3_0004, 3'd1, 64'h8765_4321_0000_0000, 0, 0, 0, 0, 0, o);
        n_cmp++;
        if (o.valids !== 1 || o.res !== 64'h8765_4321 || o.lat !== 2) begin
            n_bad++; $display("FAIL flush_next got=%h/lat%0d exp=87654321/2", o.res, o.lat);
        end
        issue_to_rvalid(3'd6, ok);
        @(negedge clk); valid_i = 0; flush_i = 1; rvalid = 1; #1;
        n_cmp++;
        if (!ok || valid_o !== 1'b0) begin
            n_bad++; $display("FAIL flush_rvalid got=ok%0d/valid%b exp=1/0", ok, valid_o);
        end
        @(negedge clk); flush_i = 0; rvalid = 0;
        run_load(LH, 64'h3_0006, 3'd0, 64'h8001_0000_0000_0000, 0, 0, 0, 0, 0, o);
        n_cmp++;
        if (o.valids !== 1 || o.res !== 64'hFFFF_FFFF_FFFF_8001 || o.lat !== 2) begin
            n_bad++; $display("FAIL flush_rvalid_next got=%h/lat%0d exp=ffffffffffff8001/2",
                o.res, o.lat);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bit ok;
        issue_to_rvalid(3'd5, ok);
        @(negedge clk); rst_i = 1; valid_i = 1; rvalid = 1; rdata = '1; #1;
        n_cmp++;
        if (!ok || valid_o !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_valid got=ok%0d/valid%b exp=1/0", ok, valid_o);
        end
        @(negedge clk); #1;
        n_cmp++;
        if ({valid_o, pop_ld_o, rq.data_req, rq.tag_valid, rq.kill_req,
             translation_req_o} !== 6'b0 || result_o !== '0 || trans_id_o !== '0) begin
            n_bad++; $display("FAIL rst_mid_outputs got=%b/%h/%0d exp=0",
                {valid_o, pop_ld_o, rq.data_req, rq.tag_valid, rq.kill_req,
                 translation_req_o}, result_o, trans_id_o);
        end
        @(negedge clk); rst_i = 0; valid_i = 0; rvalid = 0;
        run_load(LBU, 64'h10, 3'd3, 64'h42, 0, 0, 0, 0, 0, o);
        n_cmp++;
        if (o.valids !== 1 || o.res !== 64'h42 || o.lat !== 2) begin
            n_bad++; $display("FAIL rst_mid_next got=%h/lat%0d exp=42/2", o.res, o.lat);
        end
    endtask

    task automatic test_random();
        obs_t o;
        for (int i = 0; i < 40; i++) begin
            fu_op_t op = fu_op_t'($urandom_range(0, 6));
            int nb = op_bytes(op);
            logic [2:0] off = 3'($urandom_range(0, 7) & ~(nb - 1));
            logic [VLEN-1:0] va = {$urandom, $urandom};
            logic [63:0] d = {$urandom, $urandom};
            logic [TRANS_ID_BITS-1:0] tid = TRANS_ID_BITS'($urandom);
            int glat = $urandom_range(0, 2);
            int rvl = $urandom_range(0, 3);
            int miss = ($urandom_range(0, 3) == 0) ? 2 : 0;
            logic [63:0] exp;
            va[2:0] = off;
            exp = ref_load(op, off, d);
            run_load(op, va, tid, d, glat, miss, rvl, 0, 0, o);
            n_cmp++;
            if (o.valids !== 1 || o.res !== exp || o.tid !== tid) begin
                n_bad++; $display("FAIL rand_result[%0d] op=%0d off=%0d got=%h/%0d exp=%h/%0d",
                    i, op, off, o.res, o.tid, exp, tid);
            end
            n_cmp++;
            if (o.pops !== 1 || o.lat < 2 + rvl) begin
                n_bad++; $display("FAIL rand_pop_lat[%0d] got=pop%0d/lat%0d exp=1/>=%0d",
                    i, o.pops, o.lat, 2 + rvl);
            end
            n_cmp++;
            if (int'(o.size) !== $clog2(nb)) begin
                n_bad++; $display("FAIL rand_size[%0d] got=%0d exp=%0d", i, o.size, $clog2(nb));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1; flush_i = 0; valid_i = 0; lsu_ctrl_i = '0; paddr_i = '0;
        ex_i = '{cause: 64'h5, tval: 64'h1234, valid: 1'b0};
        dtlb_hit_i = 1; po_match = 0; gnt = 0; rvalid = 0; rdata = '0;
        test_reset();
        test_lw_sign();
        test_byte();
        test_tlb_miss();
        test_fault();
        test_hazard();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
